// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
// Holds sizing constants, the FSM state enum and the rotate-priority pick.
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // One-hot winner: first set bit scanning ptr, ptr+1, ... wrapping mod 8.
    function automatic logic [NUM_REQ-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr
    );
        logic [NUM_REQ-1:0] win;
        logic [IDX_W-1:0]   k;
        logic               found;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = ptr + IDX_W'(i);
            if (!found && req[k]) begin
                win[k] = 1'b1;
                found  = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/onehot8_to_bin3.sv
// Combinational 8-to-3 one-hot to binary encoder.
// An all-zero input encodes to index 0.
module onehot8_to_bin3
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx
);

    // OR together the indices of set bits; exact for one-hot or zero input.
    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (onehot[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with release and hold timeout.
// Grant, index, valid and timeout are all registered outputs.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       rel,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);

    localparam bit TO_EN = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] LAST =
        CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    state_t             state;
    state_t             state_d;
    logic [IDX_W-1:0]   ptr;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic [IDX_W-1:0]   idx_d;
    logic               to_d;
    logic               grant_now;
    logic               hold_last;
    logic               drop;

    onehot8_to_bin3 u_enc (
        .onehot (gnt_d),
        .idx    (idx_d)
    );

    assign hold_last = TO_EN && (cnt == LAST);
    assign drop      = !req[gnt_idx];
    assign grant_now = (state == IDLE) && (|req);

    // Next state, next grant, hold counter and timeout cause.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        gnt_d   = gnt;
        to_d    = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    gnt_d   = rr_pick(req, ptr);
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (rel || drop || hold_last) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                    to_d    = hold_last && !rel && !drop;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
        endcase
    end

    // State, pointer, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            gnt     <= gnt_d;
            gnt_idx <= idx_d;
            gnt_vld <= |gnt_d;
            timeout <= to_d;
            if (grant_now) begin
                ptr <= idx_d + 1'b1;
            end
        end
    end

endmodule
